// File: rtl/ram_rd_unpack_pkg.sv
// Shared constants for the sample RAM read path. Lane and word widths must match
// the ping-pong buffer's 16-bit write side and 64-bit read side.
package ram_rd_unpack_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int LANES     = 4;
  localparam int WORD_W    = SAMPLE_W * LANES;
  localparam int BLK_WORDS = 4096;

  localparam int RAM_WR_W  = 16;
  localparam int RAM_RD_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ram_rd_unpack_lane_fifo.sv
// Per-lane synchronous FIFO with an occupancy count; the head is shown
// combinationally and forced to zero while empty.
module lane_fifo
  import ram_rd_unpack_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop_req,
  output logic [W-1:0]     rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_ok;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = pop_req & valid;
  // A pop frees the slot first, so a push into a full FIFO is fine when popping.
  assign wr_ok = push & (~full | pop);
  assign ovf   = push & ~wr_ok;
  assign rdata = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ram_rd_unpack.sv
// Reads 64-bit words from the ping-pong sample RAM, splits each into four 16-bit
// lane samples and tracks half-buffer (block) boundaries.
module ram_rd_unpack #(
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 1,
  parameter int BLK_WORDS  = ram_rd_unpack_pkg::BLK_WORDS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  output logic                                 r_o_vaild,
  input  logic                                 r_o_ready,
  input  logic [ram_rd_unpack_pkg::WORD_W-1:0] rdata,
  output logic [ram_rd_unpack_pkg::WORD_W-1:0] lane_data,
  output logic [ram_rd_unpack_pkg::LANES-1:0]  lane_valid,
  input  logic [ram_rd_unpack_pkg::LANES-1:0]  lane_ready,
  output logic                                 blk_done,
  output logic                                 busy,
  output logic                                 ovf_err
);

  import ram_rd_unpack_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BLK_WORDS);
  localparam int IW = $clog2(RD_LAT + 1);

  rd_state_e                     state, state_nxt;
  logic [BW-1:0]                 word_cnt;
  logic [RD_LAT:1]               vld_pipe, last_pipe;
  logic [IW-1:0]                 inflight;
  logic                          credit_ok, fire, push, blk_last;
  logic [LANES-1:0][CW-1:0]      lane_cnt;
  logic [LANES-1:0]              lane_ovf;

  assign fire     = r_o_vaild & r_o_ready;
  assign blk_last = (word_cnt == BW'(BLK_WORDS - 1));
  assign push     = vld_pipe[RD_LAT];
  assign blk_done = push & last_pipe[RD_LAT];

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= RD_LAT; k++) inflight = inflight + IW'(vld_pipe[k]);
  end

  // Reserve a slot for every word already in flight; the fullest lane decides.
  always_comb begin
    credit_ok = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (int'(lane_cnt[i]) + int'(inflight) + 1 > FIFO_DEPTH) credit_ok = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    r_o_vaild = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:  if (en) state_nxt = ST_RUN;
      ST_RUN: begin
        r_o_vaild = en & credit_ok;
        if (!en) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (inflight == '0) state_nxt = en ? ST_RUN : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      ovf_err   <= 1'b0;
    end else begin
      state        <= state_nxt;
      // Block position survives pauses; only reset rewinds it.
      if (fire) word_cnt <= word_cnt + 1'b1;
      vld_pipe[1]  <= fire;
      last_pipe[1] <= fire & blk_last;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
      if (|lane_ovf) ovf_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_fifo #(
      .W     (SAMPLE_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CW)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wdata   (rdata[i*SAMPLE_W +: SAMPLE_W]),
      .pop_req (lane_ready[i]),
      .rdata   (lane_data[i*SAMPLE_W +: SAMPLE_W]),
      .valid   (lane_valid[i]),
      .count   (lane_cnt[i]),
      .ovf     (lane_ovf[i])
    );
  end

endmodule

// File: tb/tb_ram_rd_unpack.sv
// Randomized bench for ram_rd_unpack: a RAM model answers fires after RD_LAT
// cycles and per-lane sample queues predict lane outputs and block pulses.
module tb_ram_rd_unpack;

  localparam int LANES  = 4;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 1;
  localparam int BLK    = 16;

  logic        clk = 1'b0;
  logic        reset, en, r_o_vaild, r_o_ready, blk_done, busy, ovf_err;
  logic [63:0] rdata, lane_data;
  logic [3:0]  lane_valid, lane_ready;

  always #5 clk = ~clk;

  ram_rd_unpack #(.FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT), .BLK_WORDS(BLK)) dut (
    .clk(clk), .reset(reset), .en(en), .r_o_vaild(r_o_vaild), .r_o_ready(r_o_ready),
    .rdata(rdata), .lane_data(lane_data), .lane_valid(lane_valid), .lane_ready(lane_ready),
    .blk_done(blk_done), .busy(busy), .ovf_err(ovf_err)
  );

  int          checks, failures, cyc, fire_idx, fires, obs_blk, exp_blk_cnt;
  logic        t_en, t_rr, last_fired, got;
  logic [3:0]  t_lr;
  logic [63:0] next_word;
  logic [15:0] exp_q [LANES][$];
  int          pend_due[$], pend_idx[$];
  logic [63:0] pend_w[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) exp_q[i].delete();
    pend_due.delete(); pend_idx.delete(); pend_w.delete();
    fire_idx = 0;
  endtask

  // One clock: drive inputs at the falling edge, then check what the next rising edge will see.
  task automatic step();
    logic due, exp_blk;
    @(negedge clk);
    en = t_en; r_o_ready = t_rr; lane_ready = t_lr;
    due = (pend_due.size() > 0) && (pend_due[0] == cyc);
    rdata = due ? pend_w[0] : {$urandom(), $urandom()};
    #1;
    exp_blk = due && ((pend_idx[0] % BLK) == BLK - 1);
    chk("blk_done", blk_done, exp_blk);
    if (blk_done) obs_blk++;
    if (exp_blk) exp_blk_cnt++;
    chk("ovf_err", ovf_err, 0);
    if (!en) chk("req_when_off", r_o_vaild, 0);
    for (int i = 0; i < LANES; i++) begin
      chk("lane_valid", lane_valid[i], exp_q[i].size() != 0);
      if (lane_valid[i] && lane_ready[i] && exp_q[i].size() > 0) begin
        chk("lane_data", lane_data[16*i +: 16], exp_q[i][0]);
        void'(exp_q[i].pop_front());
      end
    end
    if (due) begin
      for (int i = 0; i < LANES; i++) begin
        exp_q[i].push_back(pend_w[0][16*i +: 16]);
        chk("occupancy", exp_q[i].size() <= DEPTH, 1);
      end
      void'(pend_due.pop_front()); void'(pend_idx.pop_front()); void'(pend_w.pop_front());
    end
    last_fired = r_o_vaild && r_o_ready;
    if (last_fired) begin
      fires++;
      pend_due.push_back(cyc + RD_LAT);
      pend_idx.push_back(fire_idx);
      pend_w.push_back(next_word);
      fire_idx++;
      next_word = {$urandom(), $urandom()};
    end
    cyc++;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; fires = 0; obs_blk = 0; exp_blk_cnt = 0;
    reset = 1'b1; en = 1'b0; r_o_ready = 1'b0; lane_ready = '0; rdata = '0;
    t_en = 1'b0; t_rr = 1'b0; t_lr = '0; last_fired = 1'b0;
    next_word = 64'h4444_3333_2222_1111;
    model_reset();
    #12;
    chk("rst_req", r_o_vaild, 0);
    chk("rst_lane_valid", lane_valid, 0);
    chk("rst_lane_data", lane_data, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    @(negedge clk); reset = 1'b0;

    // Basic unpack and first-word latency
    t_en = 1; t_rr = 1; t_lr = 4'hF;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin step(); got = last_fired; end
    chk("basic_fire", got, 1);
    step(); chk("basic_lat", lane_valid, 4'h0);
    step(); chk("basic_valid", lane_valid, 4'hF);
    chk("basic_data", lane_data, 64'h4444_3333_2222_1111);

    // Random traffic: pauses, buffer stalls, uneven lane draining
    for (int k = 0; k < 400; k++) begin
      t_en = ($urandom_range(9) != 0);
      t_rr = ($urandom_range(3) != 0);
      t_lr = 4'($urandom());
      step();
    end

    // Drain everything
    t_en = 0; t_lr = 4'hF;
    repeat (20) step();
    chk("drained_busy", busy, 0);
    chk("drained_valid", lane_valid, 0);

    // Backpressure: all lanes stalled
    t_lr = 4'h0; t_en = 1; t_rr = 1; fires = 0;
    repeat (30) step();
    chk("bp_fires", fires, DEPTH);
    chk("bp_req", r_o_vaild, 0);
    t_lr = 4'b0100; fires = 0;
    repeat (12) step();
    chk("bp_lane2_fires", fires, 0);
    chk("bp_lane2_valid", lane_valid, 4'b1011);
    t_lr = 4'hF; fires = 0;
    repeat (10) step();
    chk("bp_resume", fires > 0, 1);

    // Buffer stall mid-stream
    repeat (5) step();
    t_rr = 0; fires = 0;
    repeat (20) step();
    chk("stall_fires", fires, 0);
    chk("stall_req_held", r_o_vaild, 1);
    t_rr = 1;
    repeat (20) step();

    // Drop en with one word in flight
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin step(); got = last_fired; end
    chk("drain_fire", got, 1);
    t_en = 0;
    step();
    chk("drain_req", r_o_vaild, 0);
    chk("drain_busy", busy, 1);
    for (int k = 0; k < 10 && busy; k++) step();
    chk("drain_idle", busy, 0);

    // Continuous reads across block boundaries
    t_en = 1; t_rr = 1; t_lr = 4'hF;
    repeat (60) step();
    chk("blk_pulse_count", obs_blk, exp_blk_cnt);

    // Asynchronous reset with FIFOs half full
    t_lr = 4'h0;
    repeat (6) step();
    #3 reset = 1'b1;
    #1;
    chk("mrst_req", r_o_vaild, 0);
    chk("mrst_lane_valid", lane_valid, 0);
    chk("mrst_lane_data", lane_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_blk_done", blk_done, 0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    t_lr = 4'hF; obs_blk = 0;
    repeat (45) step();
    chk("mrst_blk_pulses", obs_blk, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
